// File: rtl/transmit_pkg.sv
// transmit_pkg
// Shared types and constants for the framed serial transmitter: the
// sequencer state encoding, buffer depth, CRC-8 polynomial and character
// geometry. It also provides a single-bit CRC-8 update helper.
// No ports (package).
package transmit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int         MAX_BYTES     = 16;
  localparam logic [7:0] CRC_POLY      = 8'h07;
  localparam int         BITS_PER_CHAR = 10;
  localparam int         LEN_W         = 4;

  // MSB-first shift-register CRC step; the caller feeds the line bits in
  // transmit order, which means LSB first within each byte.
  function automatic logic [7:0] crcStep(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/transmit_baud_tick.sv
// baud_tick
// An 8-bit reloadable down-counter that marks the last clock of each bit
// period. Loading with value B yields a tick on every B-th enabled clock.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   load_i   in   load reload_i into the counter (wins over en_i)
//   en_i     in   count enable
//   reload_i in   bit period in clocks, must be >= 1
//   tick_o   out  high on the final clock of the current period
module baud_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [7:0] reload_i,
  output logic       tick_o
);

  logic [7:0] cnt_q;

  // A counter value of 1 marks the last clock of the period. A value of 0
  // only appears after reset, and it also ticks so that a stale count cannot stall.
  assign tick_o = en_i && (cnt_q <= 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= reload_i;
    end else if (en_i) begin
      cnt_q <= tick_o ? reload_i : cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/transmit.sv
// transmit
// Framed serial transmitter. It buffers 1..16 host bytes. On send, it
// serializes a length byte, then the buffered bytes, then a CRC-8 byte.
// Each byte goes out as start/8 data (LSB first)/stop, with every bit
// lasting max(baudrate,1) clocks.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   baudrate  in   clocks per bit, latched when a send is accepted
//   datain    in   byte to buffer
//   wr        in   write strobe, one byte per cycle
//   send      in   start-frame strobe
//   tx        out  serial line, idles high
//   busy      out  frame in progress
//   full      out  buffer holds 16 bytes
//   done      out  one-cycle pulse at end of frame
//   over      out  sticky lost-write flag
module transmit
  import transmit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] baudrate,
  input  logic [7:0] datain,
  input  logic       wr,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       done,
  output logic       over
);

  localparam logic [4:0] FULL_COUNT = 5'(MAX_BYTES);
  localparam logic [2:0] LAST_BIT   = 3'(BITS_PER_CHAR - 3);

  state_t      state_q;
  logic [7:0]  bufMem [MAX_BYTES];
  logic [4:0]  count_q;
  logic [4:0]  byteIdx_q;
  logic [2:0]  bitIdx_q;
  logic [7:0]  shift_q;
  logic [7:0]  crc_q;
  logic [7:0]  baud_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        over_q;

  logic             isIdle;
  logic             wrTake;
  logic             wrDrop;
  logic             accept;
  logic             tick;
  logic             lastByte;
  logic             nextIsData;
  logic [4:0]       effCount;
  logic [LEN_W-1:0] lenVal;
  logic [7:0]       lenByte;
  logic [7:0]       baudIn;
  logic [7:0]       reloadVal;

  // A same-cycle write is counted before the send decision. Because of
  // this, wr+send with an empty buffer still starts a one-byte frame.
  assign isIdle   = (state_q == IDLE);
  assign wrTake   = wr && isIdle && (count_q != FULL_COUNT);
  assign wrDrop   = wr && !wrTake;
  assign effCount = count_q + {4'b0, wrTake};
  assign accept   = send && isIdle && (effCount != 5'd0);
  assign lenVal   = LEN_W'(effCount - 5'd1);
  assign lenByte  = {{(8 - LEN_W){1'b0}}, lenVal};

  assign baudIn    = (baudrate == 8'd0) ? 8'd1 : baudrate;
  assign reloadVal = isIdle ? baudIn : baud_q;

  // byteIdx 0 is the length byte, 1..count are data, and count+1 is the CRC.
  assign lastByte   = (byteIdx_q == count_q + 5'd1);
  assign nextIsData = (byteIdx_q < count_q);

  baud_tick u_baudTick (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .en_i    (!isIdle),
    .reload_i(reloadVal),
    .tick_o  (tick)
  );

  // Buffer storage needs no reset, because count_q decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wrTake) begin
      bufMem[count_q[3:0]] <= datain;
    end
  end

  // Frame sequencer. The line bit and CRC advance together, so the CRC
  // always reflects exactly the bits already placed on tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      byteIdx_q <= 5'd0;
      bitIdx_q  <= 3'd0;
      shift_q   <= 8'd0;
      crc_q     <= 8'd0;
      baud_q    <= 8'd1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wrDrop) begin
        over_q <= 1'b1;
      end else if (accept) begin
        over_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          count_q <= effCount;
          if (accept) begin
            state_q   <= START;
            baud_q    <= baudIn;
            crc_q     <= 8'd0;
            shift_q   <= lenByte;
            byteIdx_q <= 5'd0;
            bitIdx_q  <= 3'd0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q  <= DATA;
            bitIdx_q <= 3'd0;
            tx_q     <= shift_q[0];
            if (!lastByte) begin
              crc_q <= crcStep(crc_q, shift_q[0]);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (bitIdx_q == LAST_BIT) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              shift_q  <= {1'b0, shift_q[7:1]};
              tx_q     <= shift_q[1];
              if (!lastByte) begin
                crc_q <= crcStep(crc_q, shift_q[1]);
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (lastByte) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              count_q <= 5'd0;
            end else begin
              state_q   <= START;
              tx_q      <= 1'b0;
              byteIdx_q <= byteIdx_q + 5'd1;
              shift_q   <= nextIsData ? bufMem[byteIdx_q[3:0]] : crc_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign over = over_q;
  assign full = (count_q == FULL_COUNT);

endmodule

// File: tb/tb_transmit.sv
// tb_transmit
// Self-checking bench for the framed transmitter. Each accepted send
// pushes the expected frame bytes and busy duration into queues. Line and
// busy monitors pop those expectations and compare them as the DUT produces output.
module tb_transmit;
  import transmit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] baudrate;
  logic [7:0] datain;
  logic       wr;
  logic       send;
  logic       tx;
  logic       busy;
  logic       full;
  logic       done;
  logic       over;

  transmit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .baudrate(baudrate),
    .datain  (datain),
    .wr      (wr),
    .send    (send),
    .tx      (tx),
    .busy    (busy),
    .full    (full),
    .done    (done),
    .over    (over)
  );

  always #5 clk = ~clk;

  int         assertions = 0;
  int         failures   = 0;
  logic [7:0] byteQ[$];
  int         lenQ[$];
  logic [7:0] modelBuf[$];
  logic       modelOver  = 1'b0;
  logic       modelBusy  = 1'b0;
  logic       monEnable  = 1'b0;
  int         monBaud    = 1;
  int         framesExp  = 0;
  int         doneSeen   = 0;
  int         busyCnt    = 0;

  // Every comparison in the bench goes through this task.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference CRC. It folds one byte into the running value, taking bits LSB first.
  function automatic logic [7:0] crcFold(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[7] != d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else              c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeByte(input logic [7:0] b);
    wr     = 1'b1;
    datain = b;
    if (!modelBusy && modelBuf.size() < MAX_BYTES) modelBuf.push_back(b);
    else modelOver = 1'b1;
    step();
    wr = 1'b0;
  endtask

  // Drives send (optionally with a same-cycle write). If the model expects
  // acceptance, it also queues the frame and its busy duration.
  task automatic applyStimulus(input logic [7:0] baud, input logic withWr, input logic [7:0] b);
    logic       ovf;
    logic [7:0] crc;
    logic [7:0] lenB;
    int         eff;
    ovf = 1'b0;
    if (withWr) begin
      if (modelBuf.size() < MAX_BYTES) modelBuf.push_back(b);
      else ovf = 1'b1;
    end
    if (modelBuf.size() > 0) begin
      eff  = (baud == 8'd0) ? 1 : int'(baud);
      lenB = 8'(modelBuf.size() - 1);
      if (monEnable) begin
        crc = crcFold(8'h00, lenB);
        byteQ.push_back(lenB);
        foreach (modelBuf[i]) begin
          byteQ.push_back(modelBuf[i]);
          crc = crcFold(crc, modelBuf[i]);
        end
        byteQ.push_back(crc);
        lenQ.push_back((modelBuf.size() + 2) * BITS_PER_CHAR * eff);
        framesExp++;
        monBaud = eff;
      end
      modelOver = ovf;
      modelBusy = 1'b1;
      modelBuf.delete();
    end else if (ovf) begin
      modelOver = 1'b1;
    end
    baudrate = baud;
    datain   = b;
    wr       = withWr;
    send     = 1'b1;
    step();
    send = 1'b0;
    wr   = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      step();
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    modelBusy = 1'b0;
    step();
    step();
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      step();
      n++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    modelBusy = 1'b0;
  endtask

  // Watches the line for a number of cycles. It reports whether busy ever
  // rose or tx ever dropped.
  task automatic watchQuiet(input string tag);
    logic sawBusy;
    logic sawLow;
    sawBusy = 1'b0;
    sawLow  = 1'b0;
    repeat (8) begin
      step();
      if (busy) sawBusy = 1'b1;
      if (tx !== 1'b1) sawLow = 1'b1;
    end
    checkOutput({tag, "_busy"}, 32'(sawBusy), 32'd0);
    checkOutput({tag, "_txlow"}, 32'(sawLow), 32'd0);
  endtask

  // Line monitor. Starting from a start bit, it samples every clock of one
  // character and checks that each bit holds for the latched period. It
  // then compares the data byte against the scoreboard.
  initial begin : byteMon
    logic [9:0] bits;
    logic       stable;
    int         b;
    forever begin
      @(negedge clk);
      if (monEnable && tx === 1'b0) begin
        b      = monBaud;
        stable = 1'b1;
        bits   = '0;
        for (int i = 0; i < BITS_PER_CHAR; i++) begin
          for (int j = 0; j < b; j++) begin
            if (i != 0 || j != 0) @(negedge clk);
            if (j == 0) bits[i] = tx;
            else if (tx !== bits[i]) stable = 1'b0;
          end
        end
        checkOutput("framing", {29'd0, bits[9], bits[0], stable}, 32'b101);
        checkOutput("byte_expected", 32'(byteQ.size() != 0), 32'd1);
        if (byteQ.size() != 0) checkOutput("tx_byte", 32'(bits[8:1]), 32'(byteQ.pop_front()));
      end
    end
  end

  // Busy monitor. It measures each busy interval and expects done in the
  // first cycle after busy falls.
  always @(negedge clk) begin
    if (!monEnable) begin
      busyCnt = 0;
    end else begin
      if (done) doneSeen++;
      if (busy) begin
        busyCnt++;
      end else if (busyCnt > 0) begin
        checkOutput("busy_expected", 32'(lenQ.size() != 0), 32'd1);
        if (lenQ.size() != 0) checkOutput("busy_len", 32'(busyCnt), 32'(lenQ.pop_front()));
        checkOutput("done_at_end", 32'(done), 32'd1);
        busyCnt = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    wr       = 1'b0;
    send     = 1'b0;
    baudrate = 8'd4;
    datain   = 8'd0;
    repeat (2) step();
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_over", 32'(over), 32'd0);
    rst_n = 1'b1;
    step();
    monEnable = 1'b1;

    $display("[TB] single byte 0x01 at baud 4");
    writeByte(8'h01);
    applyStimulus(8'd4, 1'b0, 8'h00);
    checkOutput("a_busy_rise", 32'(busy), 32'd1);
    checkOutput("a_tx_start", 32'(tx), 32'd0);
    waitIdle("a");

    $display("[TB] single byte 0x00 at baud 1, then baud 0");
    writeByte(8'h00);
    applyStimulus(8'd1, 1'b0, 8'h00);
    waitIdle("b");
    writeByte(8'hC3);
    applyStimulus(8'd0, 1'b0, 8'h00);
    waitIdle("b0");

    $display("[TB] full buffer and overflow");
    for (int i = 0; i < MAX_BYTES; i++) writeByte(8'($urandom_range(0, 255)));
    checkOutput("c_full", 32'(full), 32'd1);
    checkOutput("c_over_pre", 32'(over), 32'(modelOver));
    writeByte(8'hEE);
    checkOutput("c_over_set", 32'(over), 32'(modelOver));
    checkOutput("c_full_kept", 32'(full), 32'd1);
    applyStimulus(8'd2, 1'b0, 8'h00);
    checkOutput("c_over_clear", 32'(over), 32'(modelOver));
    waitIdle("c");
    checkOutput("c_full_after", 32'(full), 32'd0);

    $display("[TB] write during frame, send with empty buffer");
    writeByte(8'hA5);
    applyStimulus(8'd3, 1'b0, 8'h00);
    repeat (10) step();
    writeByte(8'h5A);
    checkOutput("d_over_busy", 32'(over), 32'(modelOver));
    waitIdle("d");
    applyStimulus(8'd3, 1'b0, 8'h00);
    watchQuiet("d_empty");
    checkOutput("d_over_kept", 32'(over), 32'(modelOver));

    $display("[TB] baudrate change mid-frame");
    writeByte(8'h3C);
    applyStimulus(8'd4, 1'b0, 8'h00);
    repeat (20) step();
    baudrate = 8'd9;
    waitIdle("e");

    $display("[TB] reset mid-frame");
    monEnable = 1'b0;
    writeByte(8'hFF);
    applyStimulus(8'd5, 1'b0, 8'h00);
    repeat (17) step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("f_rst_tx", 32'(tx), 32'd1);
    checkOutput("f_rst_busy", 32'(busy), 32'd0);
    checkOutput("f_rst_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    modelBuf.delete();
    modelBusy = 1'b0;
    modelOver = 1'b0;
    step();
    applyStimulus(8'd5, 1'b0, 8'h00);
    watchQuiet("f_empty");
    checkOutput("f_full", 32'(full), 32'd0);
    monEnable = 1'b1;

    $display("[TB] same-cycle write+send, then back-to-back send");
    writeByte(8'h11);
    writeByte(8'h22);
    applyStimulus(8'd2, 1'b1, 8'h33);
    waitDone("g");
    applyStimulus(8'd2, 1'b1, 8'h77);
    checkOutput("h_busy_b2b", 32'(busy), 32'd1);
    checkOutput("h_tx_b2b", 32'(tx), 32'd0);
    waitIdle("h");

    checkOutput("done_count", 32'(doneSeen), 32'(framesExp));
    checkOutput("bytes_left", 32'(byteQ.size()), 32'd0);
    checkOutput("frames_left", 32'(lenQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
